// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes and entry kinds for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_SIZE     = 8;
    localparam int ROB_ID_WIDTH = 3;
    localparam int VAL_WIDTH    = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int REG_WIDTH    = 5;

    typedef enum logic [1:0] {
        ROB_KIND_REG    = 2'd0,
        ROB_KIND_BRANCH = 2'd1,
        ROB_KIND_STORE  = 2'd2
    } rob_kind_e;

endpackage

// File: rtl/rob_lookup.sv
// rtl/rob_lookup.sv - combinational operand lookup with same-cycle CDB bypass
module rob_lookup
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE     = reorder_buffer_pkg::ROB_SIZE,
    parameter int ROB_ID_WIDTH = reorder_buffer_pkg::ROB_ID_WIDTH,
    parameter int VAL_WIDTH    = reorder_buffer_pkg::VAL_WIDTH
) (
    input  logic [ROB_ID_WIDTH:0]                 i_query_lab,
    input  logic [ROB_SIZE-1:0]                   i_entry_busy,
    input  logic [ROB_SIZE-1:0]                   i_entry_ready,
    input  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]    i_entry_val,
    input  logic                                  i_rs_cdb_en,
    input  logic [ROB_ID_WIDTH:0]                 i_rs_cdb_lab,
    input  logic [VAL_WIDTH-1:0]                  i_rs_cdb_val,
    input  logic                                  i_lsb_cdb_en,
    input  logic [ROB_ID_WIDTH:0]                 i_lsb_cdb_lab,
    input  logic [VAL_WIDTH-1:0]                  i_lsb_cdb_val,
    output logic                                  o_ready,
    output logic [VAL_WIDTH-1:0]                  o_res
);

    localparam logic [ROB_ID_WIDTH-1:0] ONE_IDX = 1;

    logic [ROB_ID_WIDTH-1:0] w_idx;

    // Tags are index+1; the low bits minus one give the entry index (tag 8 -> 0-1 -> 7).
    assign w_idx = i_query_lab[ROB_ID_WIDTH-1:0] - ONE_IDX;

    always_comb begin
        o_ready = 1'b0;
        o_res   = '0;
        if (i_query_lab == '0) begin
            o_ready = 1'b1;
        end else if (i_entry_busy[w_idx] && i_entry_ready[w_idx]) begin
            o_ready = 1'b1;
            o_res   = i_entry_val[w_idx];
        end else if (i_rs_cdb_en && (i_rs_cdb_lab == i_query_lab)) begin
            o_ready = 1'b1;
            o_res   = i_rs_cdb_val;
        end else if (i_lsb_cdb_en && (i_lsb_cdb_lab == i_query_lab)) begin
            o_ready = 1'b1;
            o_res   = i_lsb_cdb_val;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with dual CDB capture and flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE     = reorder_buffer_pkg::ROB_SIZE,
    parameter int ROB_ID_WIDTH = reorder_buffer_pkg::ROB_ID_WIDTH,
    parameter int VAL_WIDTH    = reorder_buffer_pkg::VAL_WIDTH,
    parameter int ADDR_WIDTH   = reorder_buffer_pkg::ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec2rob_en,
    input  logic [4:0]              dec_rd,
    input  logic [1:0]              dec_kind,
    input  logic [ADDR_WIDTH-1:0]   dec_pred_pc,
    output logic                    rob_full,
    output logic [ROB_ID_WIDTH:0]   newTag,
    input  logic [ROB_ID_WIDTH:0]   query_lab1,
    input  logic [ROB_ID_WIDTH:0]   query_lab2,
    output logic                    ready1,
    output logic                    ready2,
    output logic [VAL_WIDTH-1:0]    res1,
    output logic [VAL_WIDTH-1:0]    res2,
    input  logic                    rs_cdb_en,
    input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
    input  logic                    lsb_cdb_en,
    input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
    output logic                    commit_en,
    output logic [ROB_ID_WIDTH:0]   commit_lab,
    output logic [VAL_WIDTH-1:0]    commit_val,
    output logic [4:0]              commit_rd,
    output logic                    rob2lsb_store_en,
    output logic                    flush,
    output logic [ADDR_WIDTH-1:0]   rob2if_pc
);

    localparam logic [ROB_ID_WIDTH-1:0] ONE_IDX    = 1;
    localparam logic [ROB_ID_WIDTH:0]   ONE_TAG    = 1;
    localparam logic [ROB_ID_WIDTH:0]   FULL_COUNT = (ROB_ID_WIDTH+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0]                r_busy;
    logic [ROB_SIZE-1:0]                r_ready;
    logic [ROB_SIZE-1:0][VAL_WIDTH-1:0] r_val;
    rob_kind_e                          r_kind    [ROB_SIZE];
    logic [4:0]                         r_rd      [ROB_SIZE];
    logic [ADDR_WIDTH-1:0]              r_pred_pc [ROB_SIZE];

    logic [ROB_ID_WIDTH-1:0] r_head;
    logic [ROB_ID_WIDTH-1:0] r_tail;
    logic [ROB_ID_WIDTH:0]   r_count;

    logic                    r_commit_en;
    logic                    r_store_en;
    logic                    r_flush;
    logic [ROB_ID_WIDTH:0]   r_commit_lab;
    logic [VAL_WIDTH-1:0]    r_commit_val;
    logic [4:0]              r_commit_rd;
    logic [ADDR_WIDTH-1:0]   r_redirect_pc;

    logic [ROB_ID_WIDTH-1:0] w_rs_idx;
    logic [ROB_ID_WIDTH-1:0] w_lsb_idx;
    logic                    w_rs_hit;
    logic                    w_lsb_hit;
    logic                    w_full;
    logic                    w_do_commit;
    logic                    w_mispredict;
    logic                    w_do_issue;
    rob_kind_e               w_head_kind;

    assign w_rs_idx     = rs_cdb2lab[ROB_ID_WIDTH-1:0] - ONE_IDX;
    assign w_lsb_idx    = lsb_cdb2lab[ROB_ID_WIDTH-1:0] - ONE_IDX;
    assign w_rs_hit     = rs_cdb_en && (rs_cdb2lab != '0) && r_busy[w_rs_idx];
    assign w_lsb_hit    = lsb_cdb_en && (lsb_cdb2lab != '0) && r_busy[w_lsb_idx];
    assign w_full       = (r_count == FULL_COUNT);
    assign w_head_kind  = r_kind[r_head];
    assign w_do_commit  = (r_count != '0) && r_busy[r_head] && r_ready[r_head];
    assign w_mispredict = w_do_commit && (w_head_kind == ROB_KIND_BRANCH)
                          && (r_val[r_head] != r_pred_pc[r_head]);
    // Fullness is judged on the pre-edge count, so a same-cycle commit never frees a slot early.
    assign w_do_issue   = dec2rob_en && !w_full && !w_mispredict;

    assign rob_full         = w_full;
    assign newTag           = {1'b0, r_tail} + ONE_TAG;
    assign commit_en        = r_commit_en & rdy_in;
    assign rob2lsb_store_en = r_store_en & rdy_in;
    assign flush            = r_flush & rdy_in;
    assign commit_lab       = r_commit_lab;
    assign commit_val       = r_commit_val;
    assign commit_rd        = r_commit_rd;
    assign rob2if_pc        = r_redirect_pc;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_busy        <= '0;
            r_ready       <= '0;
            r_val         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_kind[i]    <= ROB_KIND_REG;
                r_rd[i]      <= '0;
                r_pred_pc[i] <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_commit_en   <= 1'b0;
            r_store_en    <= 1'b0;
            r_flush       <= 1'b0;
            r_commit_lab  <= '0;
            r_commit_val  <= '0;
            r_commit_rd   <= '0;
            r_redirect_pc <= '0;
        end else if (rdy_in) begin
            r_commit_en <= 1'b0;
            r_store_en  <= 1'b0;
            r_flush     <= 1'b0;
            if (w_do_commit) begin
                r_commit_lab <= {1'b0, r_head} + ONE_TAG;
                r_commit_val <= r_val[r_head];
                r_commit_rd  <= r_rd[r_head];
                r_commit_en  <= (w_head_kind != ROB_KIND_STORE);
                r_store_en   <= (w_head_kind == ROB_KIND_STORE);
            end
            if (w_mispredict) begin
                r_flush       <= 1'b1;
                r_redirect_pc <= r_val[r_head];
                r_busy        <= '0;
                r_ready       <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                // LSB first so that an rs_cdb write to the same entry overrides it.
                if (w_lsb_hit) begin
                    r_ready[w_lsb_idx] <= 1'b1;
                    r_val[w_lsb_idx]   <= lsb_cdb2val;
                end
                if (w_rs_hit) begin
                    r_ready[w_rs_idx] <= 1'b1;
                    r_val[w_rs_idx]   <= rs_cdb2val;
                end
                if (w_do_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + ONE_IDX;
                end
                if (w_do_issue) begin
                    r_busy[r_tail]    <= 1'b1;
                    r_ready[r_tail]   <= 1'b0;
                    r_kind[r_tail]    <= rob_kind_e'(dec_kind);
                    r_rd[r_tail]      <= dec_rd;
                    r_pred_pc[r_tail] <= dec_pred_pc;
                    r_tail            <= r_tail + ONE_IDX;
                end
                case ({w_do_issue, w_do_commit})
                    2'b10:   r_count <= r_count + ONE_TAG;
                    2'b01:   r_count <= r_count - ONE_TAG;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    rob_lookup #(
        .ROB_SIZE     (ROB_SIZE),
        .ROB_ID_WIDTH (ROB_ID_WIDTH),
        .VAL_WIDTH    (VAL_WIDTH)
    ) u_lookup1 (
        .i_query_lab   (query_lab1),
        .i_entry_busy  (r_busy),
        .i_entry_ready (r_ready),
        .i_entry_val   (r_val),
        .i_rs_cdb_en   (rs_cdb_en),
        .i_rs_cdb_lab  (rs_cdb2lab),
        .i_rs_cdb_val  (rs_cdb2val),
        .i_lsb_cdb_en  (lsb_cdb_en),
        .i_lsb_cdb_lab (lsb_cdb2lab),
        .i_lsb_cdb_val (lsb_cdb2val),
        .o_ready       (ready1),
        .o_res         (res1)
    );

    rob_lookup #(
        .ROB_SIZE     (ROB_SIZE),
        .ROB_ID_WIDTH (ROB_ID_WIDTH),
        .VAL_WIDTH    (VAL_WIDTH)
    ) u_lookup2 (
        .i_query_lab   (query_lab2),
        .i_entry_busy  (r_busy),
        .i_entry_ready (r_ready),
        .i_entry_val   (r_val),
        .i_rs_cdb_en   (rs_cdb_en),
        .i_rs_cdb_lab  (rs_cdb2lab),
        .i_rs_cdb_val  (rs_cdb2val),
        .i_lsb_cdb_en  (lsb_cdb_en),
        .i_lsb_cdb_lab (lsb_cdb2lab),
        .i_lsb_cdb_val (lsb_cdb2val),
        .o_ready       (ready2),
        .o_res         (res2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        dec2rob_en;
    logic [4:0]  dec_rd;
    logic [1:0]  dec_kind;
    logic [31:0] dec_pred_pc;
    logic        rob_full;
    logic [3:0]  newTag;
    logic [3:0]  query_lab1;
    logic [3:0]  query_lab2;
    logic        ready1;
    logic        ready2;
    logic [31:0] res1;
    logic [31:0] res2;
    logic        rs_cdb_en;
    logic [3:0]  rs_cdb2lab;
    logic [31:0] rs_cdb2val;
    logic        lsb_cdb_en;
    logic [3:0]  lsb_cdb2lab;
    logic [31:0] lsb_cdb2val;
    logic        commit_en;
    logic [3:0]  commit_lab;
    logic [31:0] commit_val;
    logic [4:0]  commit_rd;
    logic        rob2lsb_store_en;
    logic        flush;
    logic [31:0] rob2if_pc;

    int n_checks = 0;
    int n_errors = 0;

    reorder_buffer dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .dec2rob_en       (dec2rob_en),
        .dec_rd           (dec_rd),
        .dec_kind         (dec_kind),
        .dec_pred_pc      (dec_pred_pc),
        .rob_full         (rob_full),
        .newTag           (newTag),
        .query_lab1       (query_lab1),
        .query_lab2       (query_lab2),
        .ready1           (ready1),
        .ready2           (ready2),
        .res1             (res1),
        .res2             (res2),
        .rs_cdb_en        (rs_cdb_en),
        .rs_cdb2lab       (rs_cdb2lab),
        .rs_cdb2val       (rs_cdb2val),
        .lsb_cdb_en       (lsb_cdb_en),
        .lsb_cdb2lab      (lsb_cdb2lab),
        .lsb_cdb2val      (lsb_cdb2val),
        .commit_en        (commit_en),
        .commit_lab       (commit_lab),
        .commit_val       (commit_val),
        .commit_rd        (commit_rd),
        .rob2lsb_store_en (rob2lsb_store_en),
        .flush            (flush),
        .rob2if_pc        (rob2if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic rs_wr(input logic [3:0] lab, input logic [31:0] val);
        rs_cdb_en  = 1'b1;
        rs_cdb2lab = lab;
        rs_cdb2val = val;
    endtask

    task automatic idle();
        dec2rob_en = 1'b0;
        rs_cdb_en  = 1'b0;
        lsb_cdb_en = 1'b0;
    endtask

    initial begin : stim
        logic [3:0] exp_tag;
        rst_in = 1'b1; rdy_in = 1'b1;
        dec2rob_en = 1'b0; dec_rd = '0; dec_kind = 2'd0; dec_pred_pc = '0;
        query_lab1 = '0; query_lab2 = '0;
        rs_cdb_en = 1'b0; rs_cdb2lab = '0; rs_cdb2val = '0;
        lsb_cdb_en = 1'b0; lsb_cdb2lab = '0; lsb_cdb2val = '0;
        clk1(); clk1();
        rst_in = 1'b0;
        #1;
        chk("rst_full", rob_full, 0);
        chk("rst_newtag", newTag, 1);
        chk("rst_commit_en", commit_en, 0);
        chk("rst_store_en", rob2lsb_store_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_commit_lab", commit_lab, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_pc", rob2if_pc, 0);

        // fill with 8 REG ops, rd = 1..8
        for (int i = 0; i < 8; i++) begin
            dec2rob_en = 1'b1; dec_kind = 2'd0; dec_rd = 5'(i + 1);
            #1;
            chk("fill_newtag", newTag, 32'(i + 1));
            clk1();
        end
        chk("full_set", rob_full, 1);
        chk("full_newtag", newTag, 1);
        clk1();
        chk("full_ignore_newtag", newTag, 1);
        chk("full_ignore_full", rob_full, 1);
        dec2rob_en = 1'b0;

        // tag 1 completes at edge t; commit visible after t+1; issue at t+1 blocked by full
        rs_wr(4'd1, 32'h2A);
        clk1();
        rs_cdb_en = 1'b0;
        chk("lat_no_early", commit_en, 0);
        dec2rob_en = 1'b1;
        clk1();
        dec2rob_en = 1'b0;
        chk("c1_en", commit_en, 1);
        chk("c1_lab", commit_lab, 1);
        chk("c1_val", commit_val, 32'h2A);
        chk("c1_rd", commit_rd, 1);
        chk("c1_full_blocked_newtag", newTag, 1);
        chk("c1_not_full", rob_full, 0);

        // tag 3 done before tag 2
        rs_wr(4'd3, 32'h33);
        clk1();
        rs_cdb_en = 1'b0;
        chk("ooo_wait0", commit_en, 0);
        clk1();
        chk("ooo_wait1", commit_en, 0);
        lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd2; lsb_cdb2val = 32'h22;
        clk1();
        lsb_cdb_en = 1'b0;
        chk("ooo_wait2", commit_en, 0);
        clk1();
        chk("ooo_c2_en", commit_en, 1);
        chk("ooo_c2_lab", commit_lab, 2);
        chk("ooo_c2_val", commit_val, 32'h22);
        clk1();
        chk("ooo_c3_en", commit_en, 1);
        chk("ooo_c3_lab", commit_lab, 3);
        chk("ooo_c3_val", commit_val, 32'h33);
        clk1();
        chk("ooo_gap", commit_en, 0);

        // both CDBs name tag 4: rs wins
        rs_wr(4'd4, 32'h44);
        lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd4; lsb_cdb2val = 32'h99;
        clk1();
        idle();
        clk1();
        chk("dual_lab", commit_lab, 4);
        chk("dual_val", commit_val, 32'h44);

        // lookup bypass
        query_lab1 = 4'd5; query_lab2 = 4'd6;
        rs_wr(4'd5, 32'h7);
        #1;
        chk("byp_ready1", ready1, 1);
        chk("byp_res1", res1, 7);
        chk("byp_ready2", ready2, 0);
        clk1();
        rs_cdb_en = 1'b0;
        #1;
        chk("stored_ready1", ready1, 1);
        chk("stored_res1", res1, 7);
        clk1();
        chk("c5_lab", commit_lab, 5);
        chk("retired_ready1", ready1, 0);
        query_lab1 = 4'd0;
        #1;
        chk("tag0_ready1", ready1, 1);
        chk("tag0_res1", res1, 0);
        query_lab2 = 4'd0;

        // drain tags 6,7,8
        rs_wr(4'd6, 32'h60);
        clk1();
        rs_wr(4'd7, 32'h70);
        clk1();
        chk("c6_lab", commit_lab, 6);
        rs_wr(4'd8, 32'h80);
        clk1();
        chk("c7_lab", commit_lab, 7);
        idle();
        clk1();
        chk("c8_lab", commit_lab, 8);
        chk("c8_val", commit_val, 32'h80);
        chk("c8_rd", commit_rd, 8);
        clk1();
        chk("drain_en", commit_en, 0);
        chk("drain_newtag", newTag, 1);

        // mispredicted branch: tag1 branch, tag2 reg ready, tag3 issued, flush
        dec2rob_en = 1'b1; dec_kind = 2'd1; dec_pred_pc = 32'h104; dec_rd = 5'd0;
        clk1();
        dec_kind = 2'd0; dec_rd = 5'd3;
        clk1();
        dec2rob_en = 1'b0;
        rs_wr(4'd2, 32'h5);
        clk1();
        dec2rob_en = 1'b1;
        rs_wr(4'd1, 32'h200);
        clk1();
        rs_cdb_en = 1'b0;
        chk("br_pre_flush", flush, 0);
        chk("br_pre_newtag", newTag, 4);
        clk1();
        dec2rob_en = 1'b0;
        query_lab1 = 4'd2;
        #1;
        chk("br_flush", flush, 1);
        chk("br_pc", rob2if_pc, 32'h200);
        chk("br_commit_lab", commit_lab, 1);
        chk("br_newtag", newTag, 1);
        chk("br_full", rob_full, 0);
        chk("br_cleared_ready1", ready1, 0);
        query_lab1 = 4'd0;
        clk1();
        chk("br_flush_pulse", flush, 0);
        chk("br_empty_no_commit", commit_en, 0);

        // correctly predicted branch
        dec2rob_en = 1'b1; dec_kind = 2'd1; dec_pred_pc = 32'h300;
        clk1();
        dec2rob_en = 1'b0;
        rs_wr(4'd1, 32'h300);
        clk1();
        rs_cdb_en = 1'b0;
        clk1();
        chk("okbr_en", commit_en, 1);
        chk("okbr_lab", commit_lab, 1);
        chk("okbr_flush", flush, 0);
        chk("okbr_newtag", newTag, 2);

        // store retires through rob2lsb_store_en
        dec2rob_en = 1'b1; dec_kind = 2'd2; dec_rd = 5'd0;
        clk1();
        dec2rob_en = 1'b0;
        lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd2; lsb_cdb2val = 32'h1000;
        clk1();
        lsb_cdb_en = 1'b0;
        clk1();
        chk("st_store_en", rob2lsb_store_en, 1);
        chk("st_commit_en", commit_en, 0);
        chk("st_lab", commit_lab, 2);

        // rdy_in low holds state
        dec2rob_en = 1'b1; dec_kind = 2'd0; dec_rd = 5'd9;
        clk1();
        dec2rob_en = 1'b0;
        rs_wr(4'd3, 32'hAB);
        clk1();
        rs_cdb_en = 1'b0;
        rdy_in = 1'b0;
        dec2rob_en = 1'b1;
        clk1();
        chk("hold_commit_en", commit_en, 0);
        chk("hold_newtag", newTag, 4);
        dec2rob_en = 1'b0;
        rdy_in = 1'b1;
        clk1();
        chk("hold_release_en", commit_en, 1);
        chk("hold_release_lab", commit_lab, 3);
        chk("hold_release_rd", commit_rd, 9);
        rdy_in = 1'b0;
        #1;
        chk("hold_gate_en", commit_en, 0);
        rdy_in = 1'b1;
        clk1();
        chk("hold_after_en", commit_en, 0);

        // 20 issue/commit pairs across the wrap point
        exp_tag = 4'd4;
        for (int k = 0; k < 20; k++) begin
            dec2rob_en = 1'b1; dec_kind = 2'd0; dec_rd = 5'(k);
            #1;
            chk("wrap_newtag", newTag, 32'(exp_tag));
            clk1();
            dec2rob_en = 1'b0;
            rs_wr(exp_tag, 32'h100 + 32'(k));
            clk1();
            rs_cdb_en = 1'b0;
            chk("wrap_quiet", commit_en, 0);
            clk1();
            chk("wrap_en", commit_en, 1);
            chk("wrap_lab", commit_lab, 32'(exp_tag));
            chk("wrap_val", commit_val, 32'h100 + 32'(k));
            exp_tag = (exp_tag == 4'd8) ? 4'd1 : exp_tag + 4'd1;
        end

        // reset mid-stream with a commit pending
        dec2rob_en = 1'b1; dec_kind = 2'd0;
        clk1(); clk1();
        dec2rob_en = 1'b0;
        rs_wr(exp_tag, 32'h55);
        clk1();
        rs_cdb_en = 1'b0;
        rst_in = 1'b1;
        clk1();
        rst_in = 1'b0;
        #1;
        chk("mrst_newtag", newTag, 1);
        chk("mrst_full", rob_full, 0);
        chk("mrst_commit_en", commit_en, 0);
        chk("mrst_commit_lab", commit_lab, 0);
        clk1();
        chk("mrst_empty", commit_en, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
